sb_packet_decoder_demux: RTL and testbench

Receive-side counterpart of the sideband packet encoder mux. It accepts deserialized 64-bit sideband phases and separates the SBINIT clock pattern from framed packets. It counts consecutive pattern phases and reassembles header-only or header+data packets into one registered output beat. It sits between the sideband RX deserializer and the SBINIT / message-decode logic.

---
 rtl/sb_pkg.sv | 37 +++
 rtl/sb_pattern_detector.sv | 64 ++++++
 rtl/sb_packet_decoder_demux.sv | 154 +++++++++++++++
 tb/tb_sb_packet_decoder_demux.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared sideband definitions for the sideband packet path.
//   SB_CLK_PATTERN : SBINIT clock pattern phase
//   SB_OPC_*       : opcode field slice within a header phase
//   SB_CP_BIT      : control (header) parity bit
//   SB_DP_BIT      : data parity bit
//   sb_opcode_e    : known sideband opcodes
//   sb_has_data()  : 1 when an opcode is followed by a data phase
package sb_pkg;

    localparam logic [63:0] SB_CLK_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

    localparam int unsigned SB_OPC_MSB = 4;
    localparam int unsigned SB_OPC_LSB = 0;
    localparam int unsigned SB_CP_BIT  = 62;
    localparam int unsigned SB_DP_BIT  = 63;

    typedef enum logic [4:0] {
        MEM32_WR   = 5'b00001,
        MEM64_WR   = 5'b00101,
        CFG_WR     = 5'b01001,
        CPL_32D    = 5'b10001,
        CPL_64D    = 5'b11001,
        MSG_WDATA  = 5'b11011,
        MSG_NODATA = 5'b10010
    } sb_opcode_e;

    function automatic logic sb_has_data(input logic [4:0] opcode);
        logic result;
        result = 1'b0;
        case (opcode)
            MEM32_WR, MEM64_WR, CFG_WR, CPL_32D, CPL_64D, MSG_WDATA: result = 1'b1;
            default:                                                  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sb_pattern_detector.sv
// SBINIT clock-pattern detector: compares phases against SB_CLK_PATTERN, counts consecutive
// matches (saturating at LockCnt) and holds a sticky lock until clear or reset.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   phase_i             : phase under test
//   phase_valid_i       : phase is eligible for pattern comparison this cycle
//   pattern_mode_i      : enable pattern comparison
//   clear_lock_i        : synchronous clear of counter and lock
//   match_o             : combinational match of the current phase
//   pattern_detected_o  : registered 1-cycle pulse per matching phase
//   pattern_locked_o    : registered lock level
module sb_pattern_detector
    import sb_pkg::*;
#(
    parameter int unsigned LockCnt = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] phase_i,
    input  logic        phase_valid_i,
    input  logic        pattern_mode_i,
    input  logic        clear_lock_i,
    output logic        match_o,
    output logic        pattern_detected_o,
    output logic        pattern_locked_o
);

    localparam logic [3:0] CntMax = 4'(LockCnt);

    logic [3:0] cnt_q;
    logic [3:0] cnt_inc;
    logic       detected_q;
    logic       locked_q;

    assign match_o = phase_valid_i && pattern_mode_i && (phase_i == SB_CLK_PATTERN);
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 4'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            detected_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            // The pulse is reported even when a clear wins over the count update.
            detected_q <= match_o;
            if (clear_lock_i) begin
                cnt_q    <= '0;
                locked_q <= 1'b0;
            end else if (match_o) begin
                cnt_q <= cnt_inc;
                if (cnt_inc == CntMax) begin
                    locked_q <= 1'b1;
                end
            end else if (phase_valid_i) begin
                // Lock is sticky: a broken run only restarts the count.
                cnt_q <= '0;
            end
        end
    end

    assign pattern_detected_o = detected_q;
    assign pattern_locked_o   = locked_q;

endmodule

// File: rtl/sb_packet_decoder_demux.sv
// Sideband RX decoder/demux: separates SBINIT clock-pattern phases from framed packets and
// reassembles header-only or header+data packets into one registered output beat.
// Optional feature macro: SB_PARITY_CHECK_EN (CP/DP parity check on each delivered packet).
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_rx_phase          : deserialized 64-bit sideband phase
//   i_rx_phase_valid    : phase qualifier (no backpressure)
//   i_pattern_mode      : compare IDLE phases against the clock pattern
//   i_clear_lock        : clear pattern counter and lock
//   o_pattern_detected  : 1-cycle pulse per matched pattern phase
//   o_pattern_locked    : lock level
//   o_header, o_data    : decoded packet (o_data = 0 for header-only packets)
//   o_has_data          : packet carried a data phase
//   o_packet_valid      : 1-cycle pulse, packet outputs valid
//   o_frame_error       : 1-cycle pulse on data-phase timeout
//   o_parity_error      : 1-cycle pulse with o_packet_valid on CP/DP mismatch
module sb_packet_decoder_demux
    import sb_pkg::*;
#(
    parameter int unsigned PATTERN_LOCK_CNT = 2,
    parameter int unsigned DATA_TIMEOUT     = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_rx_phase,
    input  logic        i_rx_phase_valid,
    input  logic        i_pattern_mode,
    input  logic        i_clear_lock,
    output logic        o_pattern_detected,
    output logic        o_pattern_locked,
    output logic [63:0] o_header,
    output logic [63:0] o_data,
    output logic        o_has_data,
    output logic        o_packet_valid,
    output logic        o_frame_error,
    output logic        o_parity_error
);

    localparam int unsigned      TmoW    = $clog2(DATA_TIMEOUT);
    localparam logic [TmoW-1:0]  TmoLast = TmoW'(DATA_TIMEOUT - 1);

    typedef enum logic {StIdle, StWaitData} state_e;

    state_e            state_q;
    logic [TmoW-1:0]   tmo_q;
    logic [63:0]       hdr_hold_q;
    logic [63:0]       header_q;
    logic [63:0]       data_q;
    logic              has_data_q;
    logic              packet_valid_q;
    logic              frame_error_q;
    logic              idle_valid;
    logic              pattern_match;

    // Data phases in WAIT_DATA never take part in pattern detection.
    assign idle_valid = i_rx_phase_valid && (state_q == StIdle);

    sb_pattern_detector #(
        .LockCnt (PATTERN_LOCK_CNT)
    ) u_pattern_detector (
        .clk_i              (i_clk),
        .rst_i              (i_rst),
        .phase_i            (i_rx_phase),
        .phase_valid_i      (idle_valid),
        .pattern_mode_i     (i_pattern_mode),
        .clear_lock_i       (i_clear_lock),
        .match_o            (pattern_match),
        .pattern_detected_o (o_pattern_detected),
        .pattern_locked_o   (o_pattern_locked)
    );

`ifdef SB_PARITY_CHECK_EN
    logic parity_error_q;

    // Data is passed as 0 for header-only packets, so DP is then expected to be 0.
    function automatic logic parity_bad(input logic [63:0] hdr, input logic [63:0] data);
        return (hdr[SB_CP_BIT] != ^hdr[SB_CP_BIT-1:0]) || (hdr[SB_DP_BIT] != ^data);
    endfunction
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= StIdle;
            tmo_q          <= '0;
            hdr_hold_q     <= '0;
            header_q       <= '0;
            data_q         <= '0;
            has_data_q     <= 1'b0;
            packet_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
`ifdef SB_PARITY_CHECK_EN
            parity_error_q <= 1'b0;
`endif
        end else begin
            packet_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
`ifdef SB_PARITY_CHECK_EN
            parity_error_q <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (i_rx_phase_valid && !pattern_match) begin
                        if (sb_has_data(i_rx_phase[SB_OPC_MSB:SB_OPC_LSB])) begin
                            hdr_hold_q <= i_rx_phase;
                            tmo_q      <= '0;
                            state_q    <= StWaitData;
                        end else begin
                            packet_valid_q <= 1'b1;
                            header_q       <= i_rx_phase;
                            data_q         <= '0;
                            has_data_q     <= 1'b0;
`ifdef SB_PARITY_CHECK_EN
                            parity_error_q <= parity_bad(i_rx_phase, 64'h0);
`endif
                        end
                    end
                end
                StWaitData: begin
                    if (i_rx_phase_valid) begin
                        packet_valid_q <= 1'b1;
                        header_q       <= hdr_hold_q;
                        data_q         <= i_rx_phase;
                        has_data_q     <= 1'b1;
                        hdr_hold_q     <= '0;
                        state_q        <= StIdle;
`ifdef SB_PARITY_CHECK_EN
                        parity_error_q <= parity_bad(hdr_hold_q, i_rx_phase);
`endif
                    end else if (tmo_q == TmoLast) begin
                        // DATA_TIMEOUT empty cycles: abandon the header without a packet.
                        frame_error_q <= 1'b1;
                        hdr_hold_q    <= '0;
                        state_q       <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_header       = header_q;
    assign o_data         = data_q;
    assign o_has_data     = has_data_q;
    assign o_packet_valid = packet_valid_q;
    assign o_frame_error  = frame_error_q;
`ifdef SB_PARITY_CHECK_EN
    assign o_parity_error = parity_error_q;
`else
    assign o_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_sb_packet_decoder_demux.sv
// Self-checking bench for sb_packet_decoder_demux: directed scenarios followed by randomized
// phase streams, all checked every cycle against a behavioural packet/pattern model.
module tb_sb_packet_decoder_demux;

    localparam int unsigned LOCK_N = 2;
    localparam int unsigned TMO    = 16;
    localparam logic [63:0] PAT    = 64'hAAAA_AAAA_AAAA_AAAA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] rx_phase = '0;
    logic        rx_valid = 1'b0;
    logic        pattern_mode = 1'b0;
    logic        clear_lock = 1'b0;
    logic        o_pattern_detected;
    logic        o_pattern_locked;
    logic [63:0] o_header;
    logic [63:0] o_data;
    logic        o_has_data;
    logic        o_packet_valid;
    logic        o_frame_error;
    logic        o_parity_error;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_wait;
    logic [63:0] m_hdr;
    int          m_waited;
    int          m_run;
    bit          m_lock;
    logic [63:0] m_header;
    logic [63:0] m_data;
    bit          m_has;
    bit          exp_pd, exp_pv, exp_fe, exp_pe;

    logic [4:0]  wd_list [6] = '{5'h01, 5'h05, 5'h09, 5'h11, 5'h19, 5'h1B};

    sb_packet_decoder_demux #(
        .PATTERN_LOCK_CNT (LOCK_N),
        .DATA_TIMEOUT     (TMO)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_rx_phase         (rx_phase),
        .i_rx_phase_valid   (rx_valid),
        .i_pattern_mode     (pattern_mode),
        .i_clear_lock       (clear_lock),
        .o_pattern_detected (o_pattern_detected),
        .o_pattern_locked   (o_pattern_locked),
        .o_header           (o_header),
        .o_data             (o_data),
        .o_has_data         (o_has_data),
        .o_packet_valid     (o_packet_valid),
        .o_frame_error      (o_frame_error),
        .o_parity_error     (o_parity_error)
    );

    always #5 clk = ~clk;

    function automatic bit is_data_opcode(input logic [4:0] opc);
        foreach (wd_list[i]) if (wd_list[i] == opc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_wait = 0; m_hdr = '0; m_waited = 0; m_run = 0; m_lock = 0;
        m_header = '0; m_data = '0; m_has = 0;
        exp_pd = 0; exp_pv = 0; exp_fe = 0; exp_pe = 0;
    endfunction

    function automatic void deliver(input logic [63:0] h, input logic [63:0] d, input bit hd);
        exp_pv = 1; m_header = h; m_data = d; m_has = hd;
`ifdef SB_PARITY_CHECK_EN
        exp_pe = (h[62] != ^h[61:0]) || (h[63] != ^d);
`else
        exp_pe = 0;
`endif
    endfunction

    function automatic void model_step(input logic v, input logic [63:0] ph, input logic pm,
                                       input logic cl);
        exp_pd = 0; exp_pv = 0; exp_fe = 0; exp_pe = 0;
        if (!m_wait) begin
            if (v) begin
                if (pm && ph == PAT) begin
                    exp_pd = 1;
                    if (m_run < LOCK_N) m_run++;
                    if (m_run == LOCK_N) m_lock = 1;
                end else begin
                    m_run = 0;
                    if (is_data_opcode(ph[4:0])) begin
                        m_wait = 1; m_hdr = ph; m_waited = 0;
                    end else begin
                        deliver(ph, 64'h0, 0);
                    end
                end
            end
        end else if (v) begin
            deliver(m_hdr, ph, 1);
            m_wait = 0;
        end else begin
            m_waited++;
            if (m_waited == TMO) begin
                exp_fe = 1; m_wait = 0;
            end
        end
        if (cl) begin
            m_run = 0; m_lock = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("pattern_detected", 64'(o_pattern_detected), 64'(exp_pd));
        check("pattern_locked", 64'(o_pattern_locked), 64'(m_lock));
        check("packet_valid", 64'(o_packet_valid), 64'(exp_pv));
        check("frame_error", 64'(o_frame_error), 64'(exp_fe));
        check("parity_error", 64'(o_parity_error), 64'(exp_pe));
        check("header", o_header, m_header);
        check("data", o_data, m_data);
        check("has_data", 64'(o_has_data), 64'(m_has));
    endtask

    task automatic step(input logic v, input logic [63:0] ph, input logic pm, input logic cl);
        rx_valid = v; rx_phase = ph; pattern_mode = pm; clear_lock = cl;
        model_step(v, ph, pm, cl);
        @(posedge clk);
        #1;
        check_outputs();
        rx_valid = 1'b0; clear_lock = 1'b0;
    endtask

    function automatic logic [63:0] good_par(input logic [63:0] h, input logic [63:0] d);
        logic [63:0] r;
        r = h;
        r[62] = ^r[61:0];
        r[63] = ^d;
        return r;
    endfunction

    function automatic logic [63:0] rand_phase();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
            0: r = PAT;
            1: r[4:0] = wd_list[$urandom_range(0, 5)];
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [63:0] h;
        logic [63:0] d;
        logic        pm;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Two consecutive patterns lock
        step(1, PAT, 1, 0);
        step(1, PAT, 1, 0);
        step(0, '0, 1, 0);
        // Broken run restarts the count; lock is sticky until cleared
        step(0, '0, 1, 1);
        step(1, PAT, 1, 0);
        step(1, 64'h0, 1, 0);
        step(1, PAT, 1, 0);
        step(1, PAT, 1, 0);
        step(0, '0, 1, 1);
        // Clear wins over a simultaneous match
        step(1, PAT, 1, 0);
        step(1, PAT, 1, 1);

        // Header-only packet
        step(1, 64'h1234_5678_9ABC_0012, 0, 0);
        // Header with data after a 3-cycle gap
        step(1, 64'h0000_1111_2222_001B, 0, 0);
        repeat (3) step(0, '0, 0, 0);
        step(1, 64'hDEAD_BEEF_0123_4567, 0, 0);
        // Data-phase timeout, then normal decode
        step(1, 64'h5555_0000_0000_0001, 0, 0);
        repeat (TMO) step(0, '0, 0, 0);
        step(1, 64'h0000_0000_0000_0012, 0, 0);
        // Pattern mode falling while waiting; pattern phase taken as data
        step(1, 64'h0F0F_0000_0000_0019, 1, 0);
        step(1, PAT, 0, 0);
        step(1, 64'h7777_0000_0000_0009, 1, 0);
        step(1, PAT, 1, 0);

        // Parity: good header-only, flipped CP, good with data
        h = good_par(64'h0123_4567_89AB_CD12, 64'h0);
        step(1, h, 0, 0);
        h[62] = ~h[62];
        step(1, h, 0, 0);
        d = 64'hCAFE_F00D_1357_9BDF;
        h = good_par(64'h0ABC_0000_0000_0005, d);
        step(1, h, 0, 0);
        step(1, d, 0, 0);
        h[63] = ~h[63];
        step(1, h, 0, 0);
        step(1, d, 0, 0);

        // Reset while a header waits for data
        step(1, 64'h0000_0000_0000_0011, 0, 0);
        #2 rst = 1'b1;
        #2;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        step(1, 64'h0000_0000_0000_0012, 0, 0);

        // Randomized streams with occasional long gaps to reach timeouts
        for (int i = 0; i < 400; i++) begin
            pm = 1'($urandom_range(0, 1));
            if (i % 50 == 25) begin
                repeat (TMO + 2) step(0, {$urandom(), $urandom()}, pm, 0);
            end
            h = rand_phase();
            if ($urandom_range(0, 1) == 1) h = good_par(h, 64'h0);
            step(1'($urandom_range(0, 3) != 0), h, pm, 1'($urandom_range(0, 19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
